// File: rtl/inst_decode_rf.sv
// Decode/register-file stage for a subset of R-type instructions: issues operands to an
// external combinational ALU and writes the result back through a three-state serial FSM.
module inst_decode_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] instr,
  output logic [31:0] Src1,
  output logic [31:0] Src2,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  input  logic [31:0] alu_result,
  output logic        issue_valid,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [15:0] retire_cnt
);

  localparam logic [5:0] FnAddu = 6'b001011;
  localparam logic [5:0] FnSubu = 6'b001101;
  localparam logic [5:0] FnAnd  = 6'b010010;
  localparam logic [5:0] FnSll  = 6'b100110;

  typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

  state_e      state_q, state_d;
  logic [31:0] rf_q [32];
  logic [4:0]  rd_q;
  logic [31:0] wb_data_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        accept, legal, is_sll;
  logic [31:0] rs_val, rt_val;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];

  always_comb begin
    legal  = 1'b0;
    is_sll = (funct == FnSll);
    if (op == 6'b000000) begin
      unique case (funct)
        FnAddu, FnSubu, FnAnd, FnSll: legal = 1'b1;
        default:                      legal = 1'b0;
      endcase
    end
  end

  // R0 is never written, but the read ports force zero so it cannot leak anything.
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

  always_comb begin
    state_d    = state_q;
    inst_ready = (state_q == StIdle);
    accept     = inst_ready && inst_valid;
    unique case (state_q)
      StIdle:  if (accept && legal) state_d = StIssue;
      StIssue: state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Funct and issue_valid are only set for the single ISSUE cycle; operands hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Src1        <= 32'd0;
      Src2        <= 32'd0;
      Shamt       <= 5'd0;
      Funct       <= 6'd0;
      issue_valid <= 1'b0;
      illegal     <= 1'b0;
      rd_q        <= 5'd0;
      wb_data_q   <= 32'd0;
      retire_cnt  <= 16'd0;
    end else begin
      Funct       <= 6'd0;
      issue_valid <= 1'b0;
      illegal     <= 1'b0;
      if (accept) begin
        if (legal) begin
          Src1        <= is_sll ? rt_val : rs_val;
          Src2        <= is_sll ? 32'd0 : rt_val;
          Shamt       <= shamt;
          Funct       <= funct;
          rd_q        <= rd;
          issue_valid <= 1'b1;
        end else begin
          illegal <= 1'b1;
        end
      end
      if (state_q == StIssue) wb_data_q <= alu_result;
      if (state_q == StWb) retire_cnt <= retire_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (state_q == StWb && rd_q != 5'd0) begin
      rf_q[rd_q] <= wb_data_q;
    end
  end

endmodule

// File: tb/tb_inst_decode_rf.sv
// Scoreboard bench for inst_decode_rf: directed instructions push expected issue operands,
// a negedge monitor pops and compares them whenever issue_valid or illegal is seen.
module tb_inst_decode_rf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] Src1, Src2;
  logic [4:0]  Shamt;
  logic [5:0]  Funct;
  logic [31:0] alu_result;
  logic        issue_valid, illegal;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic [15:0] retire_cnt;

  logic        alu_force = 1'b0;
  logic [31:0] alu_force_val = 32'd0;

  int n_pass = 0;
  int n_total = 0;
  int ill_exp = 0;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  sh;
    logic [5:0]  fn;
  } exp_t;
  exp_t exp_q[$];

  inst_decode_rf dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .instr      (instr),
    .Src1       (Src1),
    .Src2       (Src2),
    .Shamt      (Shamt),
    .Funct      (Funct),
    .alu_result (alu_result),
    .issue_valid(issue_valid),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Environment ALU; the force path seeds registers since they all reset to zero.
  always_comb begin
    alu_result = 32'd0;
    if (alu_force) alu_result = alu_force_val;
    else begin
      case (Funct)
        6'b001011: alu_result = Src1 + Src2;
        6'b001101: alu_result = Src1 - Src2;
        6'b010010: alu_result = Src1 & Src2;
        6'b100110: alu_result = Src1 << Shamt;
        default:   alu_result = 32'd0;
      endcase
    end
  end

  task automatic check(input string name, input logic [74:0] act, input logic [74:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  always @(negedge clk) begin
    if (!rst && issue_valid) begin
      if (exp_q.size() == 0) check("unexpected_issue", 75'(Funct), 75'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_operands", {Src1, Src2, Shamt, Funct}, e);
      end
    end
    if (!rst && illegal) begin
      if (ill_exp == 0) check("unexpected_illegal", 75'(illegal), 75'd0);
      else begin
        ill_exp--;
        check("illegal_pulse", 75'(illegal), 75'd1);
      end
    end
  end

  // Returns 1ns after the accept edge.
  task automatic issue(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    while (!inst_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 75'(inst_ready), 75'd1);
    inst_valid = 1'b1;
    instr = w;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
  endtask

  task automatic run_legal(input logic [31:0] w, input exp_t e, input logic [4:0] rd,
                           input logic [31:0] old_val, input logic [31:0] new_val);
    exp_q.push_back(e);
    dbg_addr = rd;
    issue(w);
    @(posedge clk);
    #1;
    check("no_bypass_in_wb", 75'(dbg_data), 75'(old_val));
    check("funct_idle_in_wb", {issue_valid, Funct}, 75'd0);
    @(posedge clk);
    #1;
    check("writeback", 75'(dbg_data), 75'(new_val));
    check("ready_after_wb", 75'(inst_ready), 75'd1);
  endtask

  task automatic run_illegal(input logic [31:0] w, input logic [4:0] rd, input logic [15:0] cnt);
    ill_exp++;
    dbg_addr = rd;
    issue(w);
    check("ready_after_illegal", 75'(inst_ready), 75'd1);
    @(posedge clk);
    #1;
    check("illegal_no_write", 75'(dbg_data), 75'd0);
    check("illegal_retire", 75'(retire_cnt), 75'(cnt));
  endtask

  initial begin
    logic [31:0] bb [9];
    int accepts;
    int bad_slot;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 75'(inst_ready), 75'd1);
    check("reset_outputs", {retire_cnt, Src1, Shamt, Funct, issue_valid, illegal}, 75'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("reset_R%0d", i), 75'(dbg_data), 75'd0);
    end

    alu_force = 1'b1;
    alu_force_val = 32'd5;
    run_legal(enc(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'b001011), '{32'd0, 32'd0, 5'd0, 6'b001011},
              5'd1, 32'd0, 32'd5);
    alu_force_val = 32'd3;
    run_legal(enc(6'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'b001011), '{32'd0, 32'd0, 5'd0, 6'b001011},
              5'd2, 32'd0, 32'd3);
    alu_force = 1'b0;
    check("retire_preload", 75'(retire_cnt), 75'd2);

    run_legal(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001011), '{32'd5, 32'd3, 5'd0, 6'b001011},
              5'd3, 32'd0, 32'd8);
    check("retire_addu", 75'(retire_cnt), 75'd3);
    run_legal(enc(6'd0, 5'd2, 5'd1, 5'd4, 5'd0, 6'b001101), '{32'd3, 32'd5, 5'd0, 6'b001101},
              5'd4, 32'd0, 32'hFFFF_FFFE);
    run_legal(enc(6'd0, 5'd2, 5'd1, 5'd5, 5'd4, 6'b100110), '{32'd5, 32'd0, 5'd4, 6'b100110},
              5'd5, 32'd0, 32'h0000_0050);
    run_legal(enc(6'd0, 5'd4, 5'd1, 5'd7, 5'd0, 6'b010010), '{32'hFFFF_FFFE, 32'd5, 5'd0, 6'b010010},
              5'd7, 32'd0, 32'd4);
    check("retire_after_ops", 75'(retire_cnt), 75'd6);

    run_illegal(enc(6'b000100, 5'd1, 5'd2, 5'd8, 5'd0, 6'b001011), 5'd8, 16'd6);
    run_illegal(enc(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'b100000), 5'd8, 16'd6);

    run_legal(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b001011), '{32'd5, 32'd3, 5'd0, 6'b001011},
              5'd0, 32'd0, 32'd0);
    check("retire_rd0", 75'(retire_cnt), 75'd7);

    for (int i = 0; i < 9; i++) bb[i] = enc(6'd0, 5'd1, 5'd1, 5'd12, 5'd0, 6'b001011);
    bb[0] = enc(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'b001011);
    bb[3] = enc(6'd0, 5'd0, 5'd2, 5'd10, 5'd1, 6'b100110);
    bb[6] = enc(6'd0, 5'd1, 5'd2, 5'd11, 5'd0, 6'b001101);
    exp_q.push_back('{32'd5, 32'd3, 5'd0, 6'b001011});
    exp_q.push_back('{32'd3, 32'd0, 5'd1, 6'b100110});
    exp_q.push_back('{32'd5, 32'd3, 5'd0, 6'b001101});
    accepts = 0;
    bad_slot = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      inst_valid = 1'b1;
      instr = bb[i];
      if (inst_ready) begin
        accepts++;
        if (i % 3 != 0) bad_slot++;
      end
    end
    @(negedge clk);
    inst_valid = 1'b0;
    check("b2b_accepts", 75'(accepts), 75'd3);
    check("b2b_spacing", 75'(bad_slot), 75'd0);
    dbg_addr = 5'd9;  #1; check("b2b_R9", 75'(dbg_data), 75'd8);
    dbg_addr = 5'd10; #1; check("b2b_R10", 75'(dbg_data), 75'd6);
    dbg_addr = 5'd11; #1; check("b2b_R11", 75'(dbg_data), 75'd2);
    dbg_addr = 5'd12; #1; check("b2b_R12", 75'(dbg_data), 75'd0);
    check("retire_b2b", 75'(retire_cnt), 75'd10);

    // Reset lands while the addu to R6 sits in WB.
    exp_q.push_back('{32'd5, 32'd3, 5'd0, 6'b001011});
    dbg_addr = 5'd6;
    issue(enc(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'b001011));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_R6", 75'(dbg_data), 75'd0);
    check("abort_state", {inst_ready, retire_cnt, Src1}, {26'd0, 1'b1, 48'd0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_R6_after", 75'(dbg_data), 75'd0);
    check("abort_ready", 75'(inst_ready), 75'd1);

    repeat (2) @(negedge clk);
    check("issue_queue_drained", 75'(exp_q.size()), 75'd0);
    check("illegal_all_seen", 75'(ill_exp), 75'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
